// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and helpers for decoder blocks
package decoder_pkg;

    typedef enum logic {
        SCAN_AUTO   = 1'b0,
        SCAN_DIRECT = 1'b1
    } scan_mode_t;

    localparam int ONEHOT_MAX_W = 8;
    localparam int ONEHOT_MAX_N = 2 ** ONEHOT_MAX_W;

    // One-hot of an index up to ONEHOT_MAX_W bits; callers slice the low 2**W bits.
    function automatic logic [ONEHOT_MAX_N-1:0] onehot_w(input logic [ONEHOT_MAX_W-1:0] idx);
        logic [ONEHOT_MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational index to one-hot decoder with optional inversion
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int W          = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic [W-1:0]      idx_i,
    output logic [2**W-1:0]   out_o
);

    localparam int N = 2 ** W;

    logic [N-1:0] hot;

    // Set the single addressed bit, then invert the whole word for active-low loads.
    always_comb begin
        hot        = '0;
        hot[idx_i] = 1'b1;
        out_o      = (ACTIVE_LOW != 0) ? ~hot : hot;
    end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with auto-scan sequencer and direct select
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int W          = 2,
    parameter int PRESCALE   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              sel_valid,
    input  logic [W-1:0]      sel,
    output logic              sel_ready,
    output logic [W-1:0]      idx,
    output logic [2**W-1:0]   out,
    output logic              wrap
);

    localparam int              CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(PRESCALE - 1);

    scan_mode_t     mode_cur;
    scan_mode_t     mode_q, mode_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  cnt_eff;
    logic           wrap_q, wrap_d;

    assign mode_cur  = scan_mode_t'(mode);
    assign sel_ready = en & mode;

    // A scan that resumes after direct mode starts a fresh prescale period,
    // so the stale count left by direct mode is ignored for that first cycle.
    assign cnt_eff = (mode_q == SCAN_DIRECT) ? '0 : count_q;

    // Next-state: en freezes everything, direct mode loads on handshake, auto mode steps.
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (en) begin
            mode_d = mode_cur;
            if (mode_cur == SCAN_DIRECT) begin
                if (sel_valid) begin
                    idx_d   = sel;
                    count_d = '0;
                end
            end else if (cnt_eff == CNT_MAX) begin
                count_d = '0;
                idx_d   = idx_q + 1'b1;
                wrap_d  = (idx_q == '1);
            end else begin
                count_d = cnt_eff + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= SCAN_AUTO;
            idx_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

    decoder_onehot #(
        .W          (W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_onehot (
        .idx_i (idx_q),
        .out_o (out)
    );

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed self-checking bench for decoder_scan
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // main instance: W=2, PRESCALE=4, active-high
    logic       rst0, en0, mode0, sv0;
    logic [1:0] sel0;
    logic       rdy0, wrap0;
    logic [1:0] idx0;
    logic [3:0] out0;

    // corner A: W=3, PRESCALE=1, active-low
    // corner B: W=1, PRESCALE=1, active-high
    logic       rst1, en1, mode1, sv1;
    logic [2:0] sel1;
    logic [0:0] sel2;
    logic       rdy1, wrap1, rdy2, wrap2;
    logic [2:0] idx1;
    logic [7:0] out1;
    logic [0:0] idx2;
    logic [1:0] out2;

    decoder_scan #(.W(2), .PRESCALE(4), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst(rst0), .en(en0), .mode(mode0), .sel_valid(sv0), .sel(sel0),
        .sel_ready(rdy0), .idx(idx0), .out(out0), .wrap(wrap0)
    );

    decoder_scan #(.W(3), .PRESCALE(1), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel_valid(sv1), .sel(sel1),
        .sel_ready(rdy1), .idx(idx1), .out(out1), .wrap(wrap1)
    );

    decoder_scan #(.W(1), .PRESCALE(1), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel_valid(sv1), .sel(sel2),
        .sel_ready(rdy2), .idx(idx2), .out(out2), .wrap(wrap2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input int i, input logic [1:0] e_idx,
                        input logic [3:0] e_out, input logic e_wrap);
        chk($sformatf("%s[%0d].idx", tag, i), {30'b0, idx0}, {30'b0, e_idx});
        chk($sformatf("%s[%0d].out", tag, i), {28'b0, out0}, {28'b0, e_out});
        chk($sformatf("%s[%0d].wrap", tag, i), {31'b0, wrap0}, {31'b0, e_wrap});
    endtask

    logic [3:0] oh4 [4];

    initial begin
        oh4[0] = 4'b0001; oh4[1] = 4'b0010; oh4[2] = 4'b0100; oh4[3] = 4'b1000;
        rst0 = 1'b1; en0 = 1'b0; mode0 = 1'b0; sv0 = 1'b0; sel0 = 2'd0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = 1'b0; sv1 = 1'b0; sel1 = 3'd0; sel2 = 1'b0;

        // reset
        step(2);
        chk0("reset", 0, 2'd0, 4'b0001, 1'b0);
        chk("reset.ready", {31'b0, rdy0}, 32'd0);

        // auto scan: idx steps every 4 edges, sel_valid ignored
        rst0 = 1'b0; en0 = 1'b1; sv0 = 1'b1; sel0 = 2'd3;
        chk("auto.ready", {31'b0, rdy0}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk0("auto", k, 2'((k / 4) % 4), oh4[(k / 4) % 4], (k == 16));
        end
        step(1);
        chk0("auto", 17, 2'd0, 4'b0001, 1'b0);

        // direct load of 2, then hold for 10 cycles
        sv0 = 1'b0; mode0 = 1'b1;
        #1;
        chk("direct.ready", {31'b0, rdy0}, 32'd1);
        sv0 = 1'b1; sel0 = 2'd2;
        step(1);
        chk0("dload", 0, 2'd2, 4'b0100, 1'b0);
        sv0 = 1'b0; sel0 = 2'd1;
        step(10);
        chk0("dhold", 0, 2'd2, 4'b0100, 1'b0);

        // mode 1 -> 0 at idx 2: advance after exactly 4 cycles
        mode0 = 1'b0;
        step(3);
        chk0("mfall", 3, 2'd2, 4'b0100, 1'b0);
        step(1);
        chk0("mfall", 4, 2'd3, 4'b1000, 1'b0);
        step(4);
        chk0("wrap2", 0, 2'd0, 4'b0001, 1'b1);

        // reach idx=1 count=2 then freeze with en low
        step(6);
        chk0("pre_hold", 0, 2'd1, 4'b0010, 1'b0);
        en0 = 1'b0; mode0 = 1'b1; sv0 = 1'b1; sel0 = 2'd3;
        #1;
        chk("hold.ready", {31'b0, rdy0}, 32'd0);
        step(5);
        chk0("hold", 5, 2'd1, 4'b0010, 1'b0);
        mode0 = 1'b0; sv0 = 1'b0; en0 = 1'b1;
        step(1);
        chk0("resume", 1, 2'd1, 4'b0010, 1'b0);
        step(1);
        chk0("resume", 2, 2'd2, 4'b0100, 1'b0);

        // reset on the edge that would have wrapped 3 -> 0
        step(4);
        chk0("pre_rst", 0, 2'd3, 4'b1000, 1'b0);
        step(3);
        chk0("pre_rst", 3, 2'd3, 4'b1000, 1'b0);
        rst0 = 1'b1;
        step(1);
        chk0("midrst", 0, 2'd0, 4'b0001, 1'b0);
        rst0 = 1'b0;
        step(3);
        chk0("postrst", 3, 2'd0, 4'b0001, 1'b0);
        step(1);
        chk0("postrst", 4, 2'd1, 4'b0010, 1'b0);

        // corners: PRESCALE=1 instances advance every cycle
        chk("cA.reset.out", {24'b0, out1}, {24'b0, 8'hFE});
        chk("cB.reset.out", {30'b0, out2}, {30'b0, 2'b01});
        rst1 = 1'b0; en1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk($sformatf("cA[%0d].idx", k), {29'b0, idx1}, 32'(k % 8));
            chk($sformatf("cA[%0d].out", k), {24'b0, out1}, {24'b0, ~(8'd1 << (k % 8))});
            chk($sformatf("cA[%0d].wrap", k), {31'b0, wrap1}, 32'(k == 8));
            chk($sformatf("cB[%0d].out", k), {30'b0, out2}, (k % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("cB[%0d].wrap", k), {31'b0, wrap2}, 32'(k % 2 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
